arbitro_memoria: RTL and testbench

Two-port arbiter and sequencer for the 256×8 data memory (`memoria_dados`). It lets two requesters share the single memory port: requester 0 is the CPU load/store path and requester 1 is the program/data loader. The block sits between both requesters and the memory, owns all memory control inputs, and returns read data to the winning requester with a one-cycle `pronto` pulse.

---
 rtl/arbitro_memoria_if.sv | 20 ++
 rtl/arbitro_memoria.sv | 93 +++++++++
 tb/tb_arbitro_memoria.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// Requester-side handshake bundle of the memory arbiter: two request ports
// plus their completion pulses and registered read results.
interface arbitro_memoria_if;
    logic       req0, req1;
    logic       we0, we1;
    logic [7:0] end0, end1;
    logic [7:0] dado0, dado1;
    logic       pronto0, pronto1;
    logic [7:0] dadoLido0, dadoLido1;

    modport master (
        output req0, req1, we0, we1, end0, end1, dado0, dado1,
        input  pronto0, pronto1, dadoLido0, dadoLido1
    );

    modport slave (
        input  req0, req1, we0, we1, end0, end1, dado0, dado1,
        output pronto0, pronto1, dadoLido0, dadoLido1
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-port arbiter/sequencer for the 256x8 data memory: grants one requester,
// issues the access for one cycle, then returns the read data with a pronto pulse.
module arbitro_memoria #(
    parameter bit PRIORIDADE_FIXA = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    arbitro_memoria_if.slave        bus,
    output logic                    ocupado,
    output logic                    concedido,
    output logic                    mem_writeEnable,
    output logic [7:0]              mem_endereco,
    output logic [7:0]              mem_dadoEntrada,
    input  logic [7:0]              mem_dadoSaida
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EMITE   = 2'd1,
        CAPTURA = 2'd2
    } estado_t;

    estado_t estado;
    logic    ultimo;     // last winner; reset to 1 so requester 0 wins the first tie
    logic    vencedor;

    always_comb begin
        vencedor = 1'b0;
        if (PRIORIDADE_FIXA)
            vencedor = !bus.req0;
        else if (bus.req0 && bus.req1)
            vencedor = !ultimo;
        else
            vencedor = bus.req1;
    end

    // NOTE: every register here is assigned with <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= OCIOSO;
            ultimo          <= 1'b1;
            ocupado         <= 1'b0;
            concedido       <= 1'b0;
            mem_writeEnable <= 1'b0;
            mem_endereco    <= 8'h00;
            mem_dadoEntrada <= 8'h00;
            bus.pronto0     <= 1'b0;
            bus.pronto1     <= 1'b0;
            bus.dadoLido0   <= 8'h00;
            bus.dadoLido1   <= 8'h00;
        end else begin
            case (estado)
                OCIOSO: begin
                    bus.pronto0 <= 1'b0;
                    bus.pronto1 <= 1'b0;
                    if (bus.req0 || bus.req1) begin
                        concedido       <= vencedor;
                        ultimo          <= vencedor;
                        mem_writeEnable <= vencedor ? bus.we1   : bus.we0;
                        mem_endereco    <= vencedor ? bus.end1  : bus.end0;
                        mem_dadoEntrada <= vencedor ? bus.dado1 : bus.dado0;
                        ocupado         <= 1'b1;
                        estado          <= EMITE;
                    end else begin
                        mem_writeEnable <= 1'b0;
                    end
                end
                EMITE: begin
                    mem_writeEnable <= 1'b0;
                    estado          <= CAPTURA;
                end
                CAPTURA: begin
                    // The memory output now reflects the granted address, written data included.
                    if (concedido) begin
                        bus.dadoLido1 <= mem_dadoSaida;
                        bus.pronto1   <= 1'b1;
                    end else begin
                        bus.dadoLido0 <= mem_dadoSaida;
                        bus.pronto0   <= 1'b1;
                    end
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    mem_writeEnable <= 1'b0;
                    ocupado         <= 1'b0;
                    estado          <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: one round-robin and one fixed-priority instance,
// each on its own behavioural 256x8 memory, checked against a transaction-level model.
module tb_arbitro_memoria;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arbitro_memoria_if if_rr ();
    arbitro_memoria_if if_fp ();

    logic       ocup_rr, conc_rr, mwe_rr;
    logic [7:0] mend_rr, mdin_rr, mdout_rr;
    logic       ocup_fp, conc_fp, mwe_fp;
    logic [7:0] mend_fp, mdin_fp, mdout_fp;

    arbitro_memoria #(.PRIORIDADE_FIXA(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(if_rr.slave),
        .ocupado(ocup_rr), .concedido(conc_rr), .mem_writeEnable(mwe_rr),
        .mem_endereco(mend_rr), .mem_dadoEntrada(mdin_rr), .mem_dadoSaida(mdout_rr)
    );

    arbitro_memoria #(.PRIORIDADE_FIXA(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(if_fp.slave),
        .ocupado(ocup_fp), .concedido(conc_fp), .mem_writeEnable(mwe_fp),
        .mem_endereco(mend_fp), .mem_dadoEntrada(mdin_fp), .mem_dadoSaida(mdout_fp)
    );

    // Memories with read-during-write returning the new data, output updated every edge.
    logic [7:0] mem_rr [256] = '{default: 8'h00};
    logic [7:0] mem_fp [256] = '{default: 8'h00};
    logic [7:0] mdout_rr_q = 8'h00;
    logic [7:0] mdout_fp_q = 8'h00;
    assign mdout_rr = mdout_rr_q;
    assign mdout_fp = mdout_fp_q;

    always @(posedge clk) begin
        if (mwe_rr) mem_rr[mend_rr] <= mdin_rr;
        mdout_rr_q <= mwe_rr ? mdin_rr : mem_rr[mend_rr];
        if (mwe_fp) mem_fp[mend_fp] <= mdin_fp;
        mdout_fp_q <= mwe_fp ? mdin_fp : mem_fp[mend_fp];
    end

    // Reference model: contents seen by each requester path and last grant.
    logic [7:0] ref_rr [256] = '{default: 8'h00};
    logic [7:0] ref_fp [256] = '{default: 8'h00};
    logic [7:0] lido_rr [2];
    logic [7:0] lido_fp [2];
    bit         ultimo_ref;
    int         n_total = 0;
    int         n_ok    = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_ok++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit vence_rr(input bit r0, input bit r1, input bit ult);
        if (r0 && r1) return !ult;
        return r1;
    endfunction

    // Entered at a negedge with the DUT idle and requests already driven;
    // returns at the negedge of the pronto cycle.
    task automatic passo_rr(input bit tardio1);
        bit         w, wr;
        logic [7:0] a, d, esperado;
        w        = vence_rr(if_rr.req0, if_rr.req1, ultimo_ref);
        wr       = w ? if_rr.we1   : if_rr.we0;
        a        = w ? if_rr.end1  : if_rr.end0;
        d        = w ? if_rr.dado1 : if_rr.dado0;
        esperado = wr ? d : ref_rr[a];
        @(negedge clk);
        check("emite_ocupado", {7'd0, ocup_rr}, 8'd1);
        check("emite_we", {7'd0, mwe_rr}, {7'd0, wr});
        check("emite_end", mend_rr, a);
        if (wr) check("emite_din", mdin_rr, d);
        check("concedido", {7'd0, conc_rr}, {7'd0, w});
        if (tardio1) if_rr.req1 = 1'b1;
        @(negedge clk);
        check("captura_ocupado", {7'd0, ocup_rr}, 8'd1);
        check("captura_we", {7'd0, mwe_rr}, 8'd0);
        check("captura_pronto", {6'd0, if_rr.pronto1, if_rr.pronto0}, 8'd0);
        @(negedge clk);
        check("pronto_par", {6'd0, if_rr.pronto1, if_rr.pronto0}, w ? 8'd2 : 8'd1);
        check("pronto_ocupado", {7'd0, ocup_rr}, 8'd0);
        check("pronto_we", {7'd0, mwe_rr}, 8'd0);
        if (wr) ref_rr[a] = d;
        lido_rr[w] = esperado;
        ultimo_ref = w;
        check("dadoLido0", if_rr.dadoLido0, lido_rr[0]);
        check("dadoLido1", if_rr.dadoLido1, lido_rr[1]);
    endtask

    task automatic passo_fp();
        bit         w, wr;
        logic [7:0] a, d, esperado;
        w        = !if_fp.req0;
        wr       = w ? if_fp.we1   : if_fp.we0;
        a        = w ? if_fp.end1  : if_fp.end0;
        d        = w ? if_fp.dado1 : if_fp.dado0;
        esperado = wr ? d : ref_fp[a];
        @(negedge clk);
        check("fp_concedido", {7'd0, conc_fp}, {7'd0, w});
        check("fp_we", {7'd0, mwe_fp}, {7'd0, wr});
        @(negedge clk);
        @(negedge clk);
        check("fp_pronto_par", {6'd0, if_fp.pronto1, if_fp.pronto0}, w ? 8'd2 : 8'd1);
        if (wr) ref_fp[a] = d;
        lido_fp[w] = esperado;
        check("fp_dadoLido0", if_fp.dadoLido0, lido_fp[0]);
        check("fp_dadoLido1", if_fp.dadoLido1, lido_fp[1]);
    endtask

    task automatic sortear(input bit n);
        logic [7:0] a;
        a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        if (n) begin
            if_rr.req1 = 1'($urandom_range(0, 1));
            if_rr.we1 = 1'($urandom_range(0, 1));
            if_rr.end1 = a;
            if_rr.dado1 = 8'($urandom);
        end else begin
            if_rr.req0 = 1'($urandom_range(0, 1));
            if_rr.we0 = 1'($urandom_range(0, 1));
            if_rr.end0 = a;
            if_rr.dado0 = 8'($urandom);
        end
    endtask

    task automatic check_zero_rr(input string tag);
        check({tag, "_ocupado"}, {7'd0, ocup_rr}, 8'd0);
        check({tag, "_concedido"}, {7'd0, conc_rr}, 8'd0);
        check({tag, "_we"}, {7'd0, mwe_rr}, 8'd0);
        check({tag, "_end"}, mend_rr, 8'd0);
        check({tag, "_din"}, mdin_rr, 8'd0);
        check({tag, "_pronto"}, {6'd0, if_rr.pronto1, if_rr.pronto0}, 8'd0);
        check({tag, "_lido0"}, if_rr.dadoLido0, 8'd0);
        check({tag, "_lido1"}, if_rr.dadoLido1, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {if_rr.req0, if_rr.req1, if_rr.we0, if_rr.we1} = 4'b0;
        {if_rr.end0, if_rr.end1, if_rr.dado0, if_rr.dado1} = 32'h0;
        {if_fp.req0, if_fp.req1, if_fp.we0, if_fp.we1} = 4'b0;
        {if_fp.end0, if_fp.end1, if_fp.dado0, if_fp.dado1} = 32'h0;
        lido_rr = '{8'h00, 8'h00};
        lido_fp = '{8'h00, 8'h00};
        ultimo_ref = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_zero_rr("reset");
        check("reset_fp_ocupado", {7'd0, ocup_fp}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of EMITE drops the write
        if_rr.req0 = 1'b1; if_rr.we0 = 1'b1; if_rr.end0 = 8'h10; if_rr.dado0 = 8'hAA;
        @(negedge clk);
        check("rst_emite_we", {7'd0, mwe_rr}, 8'd1);
        #2 rst_n = 1'b0;
        #1 check_zero_rr("rst_emite");
        if_rr.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ultimo_ref = 1'b1;
        lido_rr = '{8'h00, 8'h00};
        @(negedge clk);
        if_rr.req0 = 1'b1; if_rr.we0 = 1'b0; if_rr.end0 = 8'h10;
        passo_rr(1'b0);
        check("rst_write_dropped", if_rr.dadoLido0, 8'h00);
        if_rr.req0 = 1'b0;
        @(negedge clk);

        // Single write then back-to-back read of 0x05
        if_rr.req0 = 1'b1; if_rr.we0 = 1'b1; if_rr.end0 = 8'h05; if_rr.dado0 = 8'h3C;
        passo_rr(1'b0);
        if_rr.we0 = 1'b0;
        passo_rr(1'b0);
        check("read_05", if_rr.dadoLido0, 8'h3C);
        if_rr.req0 = 1'b0;

        // Preload 0x01/0x02, then a held tie alternates 0,1,0,1
        if_rr.req0 = 1'b1; if_rr.we0 = 1'b1; if_rr.end0 = 8'h01; if_rr.dado0 = 8'h5A;
        passo_rr(1'b0);
        if_rr.req0 = 1'b0;
        if_rr.req1 = 1'b1; if_rr.we1 = 1'b1; if_rr.end1 = 8'h02; if_rr.dado1 = 8'hC3;
        passo_rr(1'b0);
        if_rr.we1 = 1'b0; if_rr.we0 = 1'b0; if_rr.req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            passo_rr(1'b0);
            check("tie_order", {7'd0, conc_rr}, 8'(k % 2));
        end
        if_rr.req0 = 1'b0; if_rr.req1 = 1'b0;
        @(negedge clk);

        // req1 rises during requester 0's EMITE: served right after pronto0
        if_rr.req0 = 1'b1; if_rr.we0 = 1'b0; if_rr.end0 = 8'h05;
        if_rr.we1 = 1'b0; if_rr.end1 = 8'h02;
        passo_rr(1'b1);
        if_rr.req0 = 1'b0;
        passo_rr(1'b0);
        check("busy_lido1", if_rr.dadoLido1, 8'hC3);
        if_rr.req1 = 1'b0;
        @(negedge clk);

        // Back-to-back write at the top address
        if_rr.req1 = 1'b1; if_rr.we1 = 1'b1; if_rr.end1 = 8'hFF; if_rr.dado1 = 8'h81;
        passo_rr(1'b0);
        passo_rr(1'b0);
        check("b2b_lido1", if_rr.dadoLido1, 8'h81);
        if_rr.req1 = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model
        sortear(1'b0);
        sortear(1'b1);
        if (!if_rr.req0 && !if_rr.req1) if_rr.req0 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            passo_rr(1'b0);
            sortear(ultimo_ref);
            if (!(ultimo_ref ? if_rr.req0 : if_rr.req1)) sortear(!ultimo_ref);
            if (!if_rr.req0 && !if_rr.req1) if_rr.req1 = 1'b1;
        end
        if_rr.req0 = 1'b0; if_rr.req1 = 1'b0;

        // Fixed priority
        if_fp.req0 = 1'b1; if_fp.we0 = 1'b1; if_fp.end0 = 8'h01; if_fp.dado0 = 8'h11;
        passo_fp();
        if_fp.req0 = 1'b0;
        if_fp.req1 = 1'b1; if_fp.we1 = 1'b1; if_fp.end1 = 8'h02; if_fp.dado1 = 8'h22;
        passo_fp();
        if_fp.we1 = 1'b0; if_fp.we0 = 1'b0; if_fp.req0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            passo_fp();
            check("fp_always0", {7'd0, conc_fp}, 8'd0);
        end
        if_fp.req0 = 1'b0;
        passo_fp();
        check("fp_drop_req0", if_fp.dadoLido1, 8'h22);
        if_fp.req1 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
